// File: rtl/game_seq_ctrl_if.sv
// Bundle between game_seq_ctrl and the raster/button/game-logic side.
// The controller takes the slave view.
interface game_seq_ctrl_if #(
  parameter int TAIL_W = 6
);
  logic [9:0]        x_in;
  logic [9:0]        y_in;
  logic              start_btn;
  logic              pause_btn;
  logic              game_over;
  logic              game_won;
  logic [TAIL_W-1:0] tail_count;
  logic              update_tick;
  logic              logic_clear;
  logic              game_run;
  logic [2:0]        state;
  logic [2:0]        level;

  modport master (
    output x_in, y_in, start_btn, pause_btn,
    output game_over, game_won, tail_count,
    input  update_tick, logic_clear, game_run,
    input  state, level
  );

  modport slave (
    input  x_in, y_in, start_btn, pause_btn,
    input  game_over, game_won, tail_count,
    output update_tick, logic_clear, game_run,
    output state, level
  );
endinterface

// File: rtl/game_seq_ctrl.sv
// Frame-synchronous snake game sequencer, single vga_clk domain.
// Optional button debounce: GAME_SEQ_DEBOUNCE_EN.
module game_seq_ctrl #(
  parameter int TAIL_W      = 6,
  parameter int FRAME_Y     = 480,
  parameter int BASE_FRAMES = 30,
  parameter int LEVEL_DEC   = 4,
  parameter int MIN_FRAMES  = 6,
  parameter int LEVEL_STEP  = 4
) (
  input  logic           vga_clk,
  input  logic           reset,
  game_seq_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  localparam int LSH = $clog2(LEVEL_STEP);
  localparam logic signed [8:0] MIN_S = 9'(MIN_FRAMES);

  logic              frame_hit;
  logic              frame_hit_q;
  logic              frame_stb;
  logic [1:0]        btn_raw;
  logic [1:0]        s1;
  logic [1:0]        s2;
  logic [1:0]        lvl;
  logic [1:0]        lvl_q;
  logic [1:0]        ev;
  logic [2:0]        st;
  logic [2:0]        nxt;
  logic              step;
  logic [7:0]        cnt;
  logic [2:0]        lvl_r;
  logic [2:0]        lvl_new;
  logic [TAIL_W-1:0] tail_sh;
  logic signed [8:0] per_s;
  logic [7:0]        period;
  logic              wrap;
  logic              tick;
  logic              clr;
  logic              run;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_hit   <= 1'b0;
      frame_hit_q <= 1'b0;
    end else begin
      frame_hit   <= (bus.x_in == 10'd0) &&
                     (bus.y_in == 10'(FRAME_Y));
      frame_hit_q <= frame_hit;
    end
  end

  assign frame_stb = frame_hit & ~frame_hit_q;

  // bit 0 = start, bit 1 = pause
  assign btn_raw = {bus.pause_btn, bus.start_btn};

`ifdef GAME_SEQ_DEBOUNCE_EN
  logic [1:0][1:0] stab;
  logic [1:0]      deb;

  // a new level must persist across four frame strobes
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      stab <= '0;
      deb  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          stab[i] <= 2'd0;
        end else if (frame_stb) begin
          if (stab[i] == 2'd3) begin
            deb[i]  <= s2[i];
            stab[i] <= 2'd0;
          end else begin
            stab[i] <= stab[i] + 2'd1;
          end
        end
      end
    end
  end

  assign lvl = deb;
`else
  assign lvl = s2;
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl_q <= '0;
      ev    <= '0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      lvl_q <= lvl;
      ev    <= lvl & ~lvl_q;
    end
  end

  assign tail_sh = bus.tail_count >> LSH;
  assign lvl_new = (tail_sh > TAIL_W'(7)) ? 3'd7 : tail_sh[2:0];

  // signed so a deep level cannot wrap below the clamp
  assign per_s  = 9'(BASE_FRAMES) - 9'(lvl_r) * 9'(LEVEL_DEC);
  assign period = (per_s < MIN_S) ? 8'(MIN_FRAMES) : per_s[7:0];
  assign wrap   = cnt >= (period - 8'd1);

  always_comb begin
    nxt  = S_IDLE;
    step = 1'b0;
    case (st)
      S_IDLE:  nxt = ev[0] ? S_CLEAR : S_IDLE;
      S_CLEAR: nxt = S_PLAY;
      S_PLAY: begin
        if (bus.game_won) begin
          nxt = S_WON;
        end else if (bus.game_over) begin
          nxt = S_OVER;
        end else if (ev[1]) begin
          nxt = S_PAUSE;
        end else begin
          nxt  = S_PLAY;
          step = frame_stb;
        end
      end
      S_PAUSE: nxt = ev[1] ? S_PLAY : S_PAUSE;
      S_OVER:  nxt = ev[0] ? S_CLEAR : S_OVER;
      S_WON:   nxt = ev[0] ? S_CLEAR : S_WON;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      st    <= S_IDLE;
      cnt   <= 8'd0;
      lvl_r <= 3'd0;
      tick  <= 1'b0;
      clr   <= 1'b0;
      run   <= 1'b0;
    end else begin
      st   <= nxt;
      run  <= (nxt == S_PLAY);
      clr  <= (nxt == S_CLEAR);
      tick <= 1'b0;
      if (nxt == S_CLEAR) begin
        cnt   <= 8'd0;
        lvl_r <= 3'd0;
      end else if (step) begin
        if (wrap) begin
          tick  <= 1'b1;
          cnt   <= 8'd0;
          lvl_r <= lvl_new;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign bus.update_tick = tick;
  assign bus.logic_clear = clr;
  assign bus.game_run    = run;
  assign bus.state       = st;
  assign bus.level       = lvl_r;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed table, reset corner case,
// then random operations against a transaction-level model.
module tb_game_seq_ctrl;
  localparam int OP_RST   = 0;
  localparam int OP_START = 1;
  localparam int OP_PAUSE = 2;
  localparam int OP_FRM   = 3;
  localparam int OP_TAIL  = 4;
  localparam int OP_FLG   = 5;
  localparam int OP_WP    = 6;

  typedef struct {
    int op;
    int arg;
    int st;
    int lv;
    int tk;
    int cl;
  } vec_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  game_seq_ctrl_if #(.TAIL_W(6)) bus ();

  game_seq_ctrl dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  int clr_cnt = 0;

  always @(negedge vga_clk) begin
    if (bus.update_tick === 1'b1) tick_cnt++;
    if (bus.logic_clear === 1'b1) clr_cnt++;
  end

  // model state
  int m_st, m_cnt, m_lv, m_tail, m_tk, m_cl;
  bit m_ov, m_wn;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.x_in = 10'd0;
      bus.y_in = 10'd480;
      cyc(1);
      bus.x_in = 10'd1;
      cyc(3);
    end
  endtask

  task automatic press(input bit is_start);
    if (is_start) bus.start_btn = 1'b1;
    else bus.pause_btn = 1'b1;
    cyc(8);
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    cyc(8);
  endtask

  task automatic do_op(input int op, input int arg);
    logic [1:0] f;
    f = 2'(arg);
    case (op)
      OP_RST: begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
      end
      OP_START: press(1'b1);
      OP_PAUSE: press(1'b0);
      OP_FRM:   frames(arg);
      OP_TAIL: begin
        bus.tail_count = 6'(arg);
        cyc(1);
      end
      OP_FLG: begin
        bus.game_over = f[0];
        bus.game_won  = f[1];
        cyc(2);
      end
      OP_WP: begin
        bus.game_over = 1'b1;
        bus.game_won  = 1'b1;
        press(1'b0);
      end
      default: cyc(1);
    endcase
  endtask

  function automatic void m_settle();
    if (m_st == 2) begin
      if (m_wn) m_st = 5;
      else if (m_ov) m_st = 4;
    end
  endfunction

  function automatic void m_apply(input int op, input int arg);
    int per;
    case (op)
      OP_RST: begin
        m_st = 0; m_cnt = 0; m_lv = 0;
      end
      OP_START: begin
        if (m_st == 0 || m_st == 4 || m_st == 5) begin
          m_cl++;
          m_cnt = 0;
          m_lv  = 0;
          m_st  = 2;
          m_settle();
        end
      end
      OP_PAUSE: begin
        if (m_st == 2) m_st = 3;
        else if (m_st == 3) begin
          m_st = 2;
          m_settle();
        end
      end
      OP_FRM: begin
        for (int k = 0; k < arg; k++) begin
          if (m_st == 2) begin
            per = 30 - 4 * m_lv;
            if (per < 6) per = 6;
            if (m_cnt >= per - 1) begin
              m_tk++;
              m_cnt = 0;
              m_lv = m_tail / 4;
              if (m_lv > 7) m_lv = 7;
            end else begin
              m_cnt++;
            end
          end
        end
      end
      OP_TAIL: m_tail = arg;
      OP_FLG: begin
        m_ov = arg[0];
        m_wn = arg[1];
        m_settle();
      end
      default: ;
    endcase
  endfunction

  vec_t tbl[$];

  initial begin
    int t0, c0, op, arg;
    bus.x_in       = 10'd1;
    bus.y_in       = 10'd0;
    bus.start_btn  = 1'b0;
    bus.pause_btn  = 1'b0;
    bus.game_over  = 1'b0;
    bus.game_won   = 1'b0;
    bus.tail_count = '0;

    tbl.push_back('{OP_RST,   0, 0, 0, 0, 0});
    tbl.push_back('{OP_TAIL,  0, 0, 0, 0, 0});
    tbl.push_back('{OP_START, 0, 2, 0, 0, 1});
    tbl.push_back('{OP_FRM,  29, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,   1, 2, 0, 1, 0});
    tbl.push_back('{OP_FRM,  30, 2, 0, 1, 0});
    tbl.push_back('{OP_TAIL,  8, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,  29, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,   1, 2, 2, 1, 0});
    tbl.push_back('{OP_FRM,  21, 2, 2, 0, 0});
    tbl.push_back('{OP_FRM,   1, 2, 2, 1, 0});
    tbl.push_back('{OP_TAIL, 63, 2, 2, 0, 0});
    tbl.push_back('{OP_FRM,  22, 2, 7, 1, 0});
    tbl.push_back('{OP_FRM,   5, 2, 7, 0, 0});
    tbl.push_back('{OP_FRM,   1, 2, 7, 1, 0});
    tbl.push_back('{OP_FRM,  12, 2, 7, 2, 0});
    tbl.push_back('{OP_TAIL,  0, 2, 7, 0, 0});
    tbl.push_back('{OP_FRM,   6, 2, 0, 1, 0});
    tbl.push_back('{OP_FRM,  10, 2, 0, 0, 0});
    tbl.push_back('{OP_PAUSE, 0, 3, 0, 0, 0});
    tbl.push_back('{OP_FRM,  50, 3, 0, 0, 0});
    tbl.push_back('{OP_FLG,   3, 3, 0, 0, 0});
    tbl.push_back('{OP_FLG,   0, 3, 0, 0, 0});
    tbl.push_back('{OP_START, 0, 3, 0, 0, 0});
    tbl.push_back('{OP_PAUSE, 0, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,  19, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,   1, 2, 0, 1, 0});
    tbl.push_back('{OP_TAIL, 12, 2, 0, 0, 0});
    tbl.push_back('{OP_FRM,  30, 2, 3, 1, 0});
    tbl.push_back('{OP_FRM,   5, 2, 3, 0, 0});
    tbl.push_back('{OP_WP,    0, 5, 3, 0, 0});
    tbl.push_back('{OP_FLG,   0, 5, 3, 0, 0});
    tbl.push_back('{OP_PAUSE, 0, 5, 3, 0, 0});
    tbl.push_back('{OP_START, 0, 2, 0, 0, 1});
    tbl.push_back('{OP_START, 0, 2, 0, 0, 0});
    tbl.push_back('{OP_FLG,   1, 4, 0, 0, 0});
    tbl.push_back('{OP_FLG,   0, 4, 0, 0, 0});
    tbl.push_back('{OP_START, 0, 2, 0, 0, 1});

    foreach (tbl[i]) begin
      t0 = tick_cnt;
      c0 = clr_cnt;
      do_op(tbl[i].op, tbl[i].arg);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.state), tbl[i].st);
      chk($sformatf("vec%0d_level", i), 32'(bus.level), tbl[i].lv);
      chk($sformatf("vec%0d_ticks", i), tick_cnt - t0, tbl[i].tk);
      chk($sformatf("vec%0d_clears", i), clr_cnt - c0, tbl[i].cl);
      chk($sformatf("vec%0d_run", i), 32'(bus.game_run),
          32'(tbl[i].st == 2));
    end

    // reset arrives one cycle before a due tick
    do_op(OP_RST, 0);
    bus.tail_count = '0;
    do_op(OP_START, 0);
    frames(29);
    t0 = tick_cnt;
    bus.x_in = 10'd0;
    bus.y_in = 10'd480;
    cyc(1);
    bus.x_in = 10'd1;
    reset = 1'b1;
    cyc(1);
    #1;
    chk("rst_tick", 32'(bus.update_tick), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_run", 32'(bus.game_run), 0);
    chk("rst_clear", 32'(bus.logic_clear), 0);
    reset = 1'b0;
    cyc(4);
    chk("rst_no_tick", tick_cnt - t0, 0);

    // random operations against the model
    do_op(OP_RST, 0);
    bus.game_over = 1'b0;
    bus.game_won  = 1'b0;
    do_op(OP_TAIL, 0);
    m_st = 0; m_cnt = 0; m_lv = 0; m_tail = 0;
    m_ov = 0; m_wn = 0; m_tk = 0; m_cl = 0;
    t0 = tick_cnt;
    c0 = clr_cnt;
    for (int n = 0; n < 200; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        op = OP_FRM; arg = $urandom_range(1, 40);
      end else if (r < 52) begin
        op = OP_TAIL; arg = $urandom_range(0, 63);
      end else if (r < 68) begin
        op = OP_START; arg = 0;
      end else if (r < 82) begin
        op = OP_PAUSE; arg = 0;
      end else if (r < 90) begin
        op = OP_FLG;
        arg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      end else begin
        op = OP_FRM; arg = $urandom_range(1, 8);
      end
      do_op(op, arg);
      m_apply(op, arg);
      #1;
      chk($sformatf("rnd%0d_state", n), 32'(bus.state), m_st);
      chk($sformatf("rnd%0d_level", n), 32'(bus.level), m_lv);
      chk($sformatf("rnd%0d_ticks", n), tick_cnt - t0, m_tk);
      chk($sformatf("rnd%0d_clears", n), clr_cnt - c0, m_cl);
    end

`ifdef GAME_SEQ_DEBOUNCE_EN
    do_op(OP_RST, 0);
    bus.start_btn = 1'b1;
    frames(2);
    bus.start_btn = 1'b0;
    frames(6);
    #1;
    chk("deb_glitch_state", 32'(bus.state), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_seq_ctrl.md
# game_seq_ctrl

Frame-synchronous game sequencer between the VGA timing path and the snake game logic. It watches the raster position to find the start of vertical blanking and runs the game state machine (idle, clear, play, pause, over, won). In play it issues one-cycle `update_tick` strobes at a frame period that shrinks as the tail grows. It replaces the free-running update clock with a single-clock enable scheme.

## Interface
Parameters:
- `TAIL_W`, 6: width of `tail_count`.
- `FRAME_Y`, 480: raster line whose `x_in==0` pixel marks a frame boundary.
- `BASE_FRAMES`, 30: frames per update at level 0; must be 1..255.
- `LEVEL_DEC`, 4: frames removed per level.
- `MIN_FRAMES`, 6: lower clamp on the period; must be ≥1.
- `LEVEL_STEP`, 4: tail segments per level; must be a power of two.

Ports:
- `vga_clk`, in, 1: pixel clock, the only clock.
- `reset`, in, 1: synchronous, active-high.
- `x_in`, in, 10: current raster X.
- `y_in`, in, 10: current raster Y.
- `start_btn`, in, 1: asynchronous push button.
- `pause_btn`, in, 1: asynchronous push button.
- `game_over`, in, 1: level from game logic.
- `game_won`, in, 1: level from game logic.
- `tail_count`, in, TAIL_W: current score.
- `update_tick`, out, 1: one-cycle game-step enable.
- `logic_clear`, out, 1: one-cycle game-logic clear.
- `game_run`, out, 1: high in PLAY.
- `state`, out, 3: encoded FSM state.
- `level`, out, 3: current speed level.

## Operation
- **Frame strobe:** `frame_hit` is the registered value of (`x_in==0 && y_in==FRAME_Y`). `frame_stb` is the rising edge of `frame_hit`, so it fires exactly once per frame.
- **Buttons:** each button passes through a 2-flop synchronizer. Rising-edge detect then gives `start_ev` and `pause_ev`, one cycle each.
- **States and encoding:** IDLE=0, CLEAR=1, PLAY=2, PAUSE=3, OVER=4, WON=5. Codes 6 and 7 go to IDLE.
- **IDLE:** `start_ev` goes to CLEAR.
- **CLEAR:** lasts exactly one cycle with `logic_clear`=1. It zeroes the frame counter and `level`, then goes to PLAY.
- **PLAY**, checked in this priority order:
  - `game_won` goes to WON.
  - else `game_over` goes to OVER.
  - else `pause_ev` goes to PAUSE.
  - else the frame counter runs as described below.
  - `start_ev` is ignored.
- **PAUSE:** the counter holds. `pause_ev` returns to PLAY, `start_ev` is ignored, and `game_over`/`game_won` are ignored.
- **OVER/WON:** `start_ev` goes to CLEAR. These states are otherwise sticky.
- **Frame counter:** 8 bits. On each `frame_stb` in PLAY:
  - if count == period−1: pulse `update_tick`, set count to 0, reload `level`;
  - else increment count.
- **Level:** `level` = min(`tail_count` / LEVEL_STEP, 7), computed with a shift. It is sampled only at the `update_tick` cycle.
- **Period:** period = max(BASE_FRAMES − level·LEVEL_DEC, MIN_FRAMES). Compute with a signed 9-bit intermediate so the subtraction cannot underflow.
- **Period change:** a new period takes effect from the next count cycle. The count is never reset by a level change. If count ≥ new period−1 at the next strobe, tick and wrap to 0.
- **Simultaneous events:** `pause_ev` and `frame_stb` in the same PLAY cycle go to PAUSE and do not tick.

## Timing
- **Reset values:** state IDLE, count 0, `level` 0, synchronizer/edge registers 0, and every output 0.
- **Reset mid-operation:** it takes effect at the next edge and no pending tick is emitted.
- **`update_tick` latency:** the match is sampled at edge N and `frame_hit`=1 after N. `frame_stb` is valid in the cycle after edge N, so `update_tick` is high in the cycle after edge N+1. The pulse is exactly one cycle wide.
- **Button latency:**
  - pin change to `start_ev`/`pause_ev`: 3 edges;
  - event to state change: 1 edge;
  - `logic_clear` is high during the cycle after entering CLEAR is registered.
- **Output registration:** `game_run` and `state` are registered and change at the same edge as the state register.

## Configuration
- Macro: `GAME_SEQ_DEBOUNCE_EN`.
- **Defined:**
  - Each synchronized button also needs a 2-bit stable counter, advanced only on `frame_stb`.
  - An edge is accepted only after the level has been stable for 4 consecutive frame strobes.
  - Added latency is up to 4 frames.
- **Undefined:** synchronizer plus edge detect only, as described above.

## Test plan
All scenarios use default parameters.
- **Start and base period:** reset, then raise `start_btn` for 10 cycles with `tail_count`=0.
  - `logic_clear` pulses once and `state` goes 1 then 2.
  - `update_tick` fires every 30 frame strobes.
  - No `update_tick` before the 30th strobe.
- **Level 2:** set `tail_count`=8 during PLAY.
  - After the next tick `level`=2.
  - Following ticks are 22 frames apart.
- **Period clamp:** `tail_count`=63.
  - `level` saturates at 7.
  - Period clamps to 6 frames (30−28=2 is below the minimum).
- **Pause:** `pause_ev` at count 10, hold for 50 frames, then `pause_ev` again.
  - No ticks while paused.
  - The next tick comes 20 frames after resume.
- **Simultaneous PLAY events:** assert `game_over` and `game_won` together with `pause_ev`.
  - `state` goes to 5 (WON).
  - `start_ev` then produces CLEAR with `level`=0.
- **Reset mid-operation:** assert `reset` one cycle before an expected tick.
  - No `update_tick`.
  - All outputs 0 and `state`=0 on the next cycle.
  - With `GAME_SEQ_DEBOUNCE_EN`, a 2-frame button glitch produces no `start_ev`.
